// File: rtl/decode_stage_if.sv
// decode_stage_if: bundles the instruction-queue, redirect, branch-predictor
// and dispatcher signals of decode_stage.
//   slave  : the decode stage's view (consumes instructions, drives results)
//   master : the environment's view (instruction queue + dispatcher side)
// Signal names match the stage's port list so traces read against the
// block documentation directly.
interface decode_stage_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  localparam int INST_TYPE_W = 6;
  localparam int REG_W       = 5;

  // instruction queue -> stage
  logic                   iq_valid_in;
  logic [DATA_W-1:0]      iq_inst_in;
  logic [ADDR_W-1:0]      iq_pc_in;
  logic                   iq_ready_out;
  logic                   iq_rst_out;
  // fetch redirect / branch-predictor query
  logic                   if_en_out;
  logic [ADDR_W-1:0]      if_addr_out;
  logic                   bp_en_out;
  logic [ADDR_W-1:0]      bp_pc_out;
  // stage -> dispatcher
  logic                   disp_valid_out;
  logic                   disp_ready_in;
  logic [INST_TYPE_W-1:0] disp_opcode_out;
  logic [REG_W-1:0]       disp_rs_out;
  logic [REG_W-1:0]       disp_rt_out;
  logic [REG_W-1:0]       disp_rd_out;
  logic [DATA_W-1:0]      disp_imm_out;
  logic [ADDR_W-1:0]      disp_pc_out;
  logic                   disp_illegal_out;

  modport slave (
    input  iq_valid_in, iq_inst_in, iq_pc_in, disp_ready_in,
    output iq_ready_out, iq_rst_out, if_en_out, if_addr_out, bp_en_out,
           bp_pc_out, disp_valid_out, disp_opcode_out, disp_rs_out,
           disp_rt_out, disp_rd_out, disp_imm_out, disp_pc_out,
           disp_illegal_out
  );

  modport master (
    output iq_valid_in, iq_inst_in, iq_pc_in, disp_ready_in,
    input  iq_ready_out, iq_rst_out, if_en_out, if_addr_out, bp_en_out,
           bp_pc_out, disp_valid_out, disp_opcode_out, disp_rs_out,
           disp_rt_out, disp_rd_out, disp_imm_out, disp_pc_out,
           disp_illegal_out
  );
endinterface

// File: rtl/decode_stage.sv
// decode_stage: registered RV32I decoder between instruction queue and
// dispatcher. One instruction per cycle is decoded and written into a
// DEPTH-entry FIFO; the FIFO head is presented to the dispatcher.
// A JAL push raises a one-cycle fetch redirect (if_en_out/iq_rst_out) on the
// following cycle; a BRANCH push raises a one-cycle predictor query.
// Ports:
//   clk_in   : clock, rising edge
//   rst_in   : synchronous reset, active high (beats rdy_in and flush_in)
//   rdy_in   : global enable; low freezes all state and masks pulses
//   flush_in : commit-side flush, empties the FIFO and drops pending pulses
//   bus      : decode_stage_if.slave (queue, redirect, predictor, dispatcher)
// Opcode encoding (disp_opcode_out):
//   0 NOP  1 LUI  2 AUIPC 3 JAL  4 JALR  5 BEQ  6 BNE  7 BLT  8 BGE  9 BLTU
//  10 BGEU 11 LB 12 LH 13 LW 14 LBU 15 LHU 16 SB 17 SH 18 SW 19 ADDI
//  20 SLTI 21 SLTIU 22 XORI 23 ORI 24 ANDI 25 SLLI 26 SRLI 27 SRAI 28 ADD
//  29 SUB 30 SLL 31 SLT 32 SLTU 33 XOR 34 SRL 35 SRA 36 OR 37 AND
// ADDR_W must not exceed DATA_W (the JAL target uses the low ADDR_W bits of
// the immediate) and DATA_W must be at least 32.
module decode_stage #(
  parameter int DEPTH  = 2,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic           clk_in,
  input  logic           rst_in,
  input  logic           rdy_in,
  input  logic           flush_in,
  decode_stage_if.slave  bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int OP_W  = 6;
  localparam int REG_W = 5;

  typedef enum logic [OP_W-1:0] {
    OP_NOP  = 6'd0,  OP_LUI  = 6'd1,  OP_AUIPC = 6'd2,  OP_JAL  = 6'd3,
    OP_JALR = 6'd4,  OP_BEQ  = 6'd5,  OP_BNE   = 6'd6,  OP_BLT  = 6'd7,
    OP_BGE  = 6'd8,  OP_BLTU = 6'd9,  OP_BGEU  = 6'd10, OP_LB   = 6'd11,
    OP_LH   = 6'd12, OP_LW   = 6'd13, OP_LBU   = 6'd14, OP_LHU  = 6'd15,
    OP_SB   = 6'd16, OP_SH   = 6'd17, OP_SW    = 6'd18, OP_ADDI = 6'd19,
    OP_SLTI = 6'd20, OP_SLTIU= 6'd21, OP_XORI  = 6'd22, OP_ORI  = 6'd23,
    OP_ANDI = 6'd24, OP_SLLI = 6'd25, OP_SRLI  = 6'd26, OP_SRAI = 6'd27,
    OP_ADD  = 6'd28, OP_SUB  = 6'd29, OP_SLL   = 6'd30, OP_SLT  = 6'd31,
    OP_SLTU = 6'd32, OP_XOR  = 6'd33, OP_SRL   = 6'd34, OP_SRA  = 6'd35,
    OP_OR   = 6'd36, OP_AND  = 6'd37
  } inst_type_e;

  typedef struct packed {
    inst_type_e        op;
    logic [REG_W-1:0]  rs;
    logic [REG_W-1:0]  rt;
    logic [REG_W-1:0]  rd;
    logic [DATA_W-1:0] imm;
    logic [ADDR_W-1:0] pc;
    logic              illegal;
  } entry_t;

  // ---------------------------------------------------------------------
  // Combinational decode of the offered instruction
  // ---------------------------------------------------------------------
  logic [DATA_W-1:0] inst;
  logic [6:0]        major;
  logic [2:0]        f3;
  logic              b30;
  logic [REG_W-1:0]  rs1, rs2, rdf;
  logic [DATA_W-1:0] imm_i, imm_s, imm_b, imm_j, imm_u, imm_sh;

  assign inst   = bus.iq_inst_in;
  assign major  = inst[6:0];
  assign f3     = inst[14:12];
  assign b30    = inst[30];
  assign rs1    = inst[19:15];
  assign rs2    = inst[24:20];
  assign rdf    = inst[11:7];
  assign imm_i  = {{(DATA_W-12){inst[31]}}, inst[31:20]};
  assign imm_s  = {{(DATA_W-12){inst[31]}}, inst[31:25], inst[11:7]};
  assign imm_b  = {{(DATA_W-12){inst[31]}}, inst[7], inst[30:25], inst[11:8], 1'b0};
  assign imm_j  = {{(DATA_W-20){inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0};
  assign imm_u  = DATA_W'({inst[31:12], 12'b0});
  assign imm_sh = DATA_W'(inst[24:20]);

  entry_t dec;
  logic   dec_jal, dec_br, bad;

  always_comb begin
    dec      = '0;
    dec.pc   = bus.iq_pc_in;
    dec_jal  = 1'b0;
    dec_br   = 1'b0;
    bad      = 1'b0;
    case (major)
      7'h33: begin
        dec.rs = rs1; dec.rt = rs2; dec.rd = rdf;
        case (f3)
          3'd0: dec.op = b30 ? OP_SUB : OP_ADD;
          3'd1: dec.op = OP_SLL;
          3'd2: dec.op = OP_SLT;
          3'd3: dec.op = OP_SLTU;
          3'd4: dec.op = OP_XOR;
          3'd5: dec.op = b30 ? OP_SRA : OP_SRL;
          3'd6: dec.op = OP_OR;
          default: dec.op = OP_AND;
        endcase
      end
      7'h13: begin
        dec.rs = rs1; dec.rd = rdf; dec.imm = imm_i;
        case (f3)
          3'd0: dec.op = OP_ADDI;
          3'd1: begin dec.op = OP_SLLI; dec.imm = imm_sh; end
          3'd2: dec.op = OP_SLTI;
          3'd3: dec.op = OP_SLTIU;
          3'd4: dec.op = OP_XORI;
          3'd5: begin dec.op = b30 ? OP_SRAI : OP_SRLI; dec.imm = imm_sh; end
          3'd6: dec.op = OP_ORI;
          default: dec.op = OP_ANDI;
        endcase
      end
      7'h03: begin
        dec.rs = rs1; dec.rd = rdf; dec.imm = imm_i;
        case (f3)
          3'd0: dec.op = OP_LB;
          3'd1: dec.op = OP_LH;
          3'd2: dec.op = OP_LW;
          3'd4: dec.op = OP_LBU;
          3'd5: dec.op = OP_LHU;
          default: bad = 1'b1;
        endcase
      end
      7'h23: begin
        dec.rs = rs1; dec.rt = rs2; dec.imm = imm_s;
        case (f3)
          3'd0: dec.op = OP_SB;
          3'd1: dec.op = OP_SH;
          3'd2: dec.op = OP_SW;
          default: bad = 1'b1;
        endcase
      end
      7'h63: begin
        dec.rs = rs1; dec.rt = rs2; dec.imm = imm_b; dec_br = 1'b1;
        case (f3)
          3'd0: dec.op = OP_BEQ;
          3'd1: dec.op = OP_BNE;
          3'd4: dec.op = OP_BLT;
          3'd5: dec.op = OP_BGE;
          3'd6: dec.op = OP_BLTU;
          3'd7: dec.op = OP_BGEU;
          default: bad = 1'b1;
        endcase
      end
      7'h6F: begin
        dec.op = OP_JAL; dec.rd = rdf; dec.imm = imm_j; dec_jal = 1'b1;
      end
      7'h67: begin
        dec.op = OP_JALR; dec.rs = rs1; dec.rd = rdf; dec.imm = imm_i;
      end
      7'h17: begin dec.op = OP_AUIPC; dec.rd = rdf; dec.imm = imm_u; end
      7'h37: begin dec.op = OP_LUI;   dec.rd = rdf; dec.imm = imm_u; end
      default: bad = 1'b1;
    endcase
    // Illegal encodings collapse to a bare NOP carrying only its pc and the
    // illegal flag, and never raise a redirect or predictor query.
    if (bad) begin
      dec         = '0;
      dec.pc      = bus.iq_pc_in;
      dec.illegal = 1'b1;
      dec_br      = 1'b0;
    end
  end

  logic [ADDR_W-1:0] jal_tgt;
  assign jal_tgt = bus.iq_pc_in + imm_j[ADDR_W-1:0];

  // ---------------------------------------------------------------------
  // Output FIFO
  // ---------------------------------------------------------------------
  entry_t            mem [DEPTH];
  logic [PTR_W-1:0]  wptr, rptr;
  logic [CNT_W-1:0]  cnt;
  logic              push, pop, head_vld;
  entry_t            head;

  // Ready looks only at the registered count: a full FIFO refuses a push
  // even when the dispatcher is popping in the same cycle.
  assign bus.iq_ready_out = (cnt != CNT_W'(DEPTH)) && !flush_in && rdy_in;
  assign push     = bus.iq_valid_in && bus.iq_ready_out;
  assign head_vld = (cnt != '0);
  assign pop      = head_vld && bus.disp_ready_in && rdy_in && !flush_in;
  // Empty FIFO presents an all-zero entry (NOP) rather than stale storage.
  assign head     = head_vld ? mem[rptr] : '0;

  always_ff @(posedge clk_in) begin
    if (push && !rst_in) mem[wptr] <= dec;
  end

  // Redirect / query pulses, registered one cycle after the push.
  logic              if_en_q, bp_en_q;
  logic [ADDR_W-1:0] if_addr_q, bp_pc_q;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      cnt       <= '0;
      wptr      <= '0;
      rptr      <= '0;
      if_en_q   <= 1'b0;
      bp_en_q   <= 1'b0;
      if_addr_q <= '0;
      bp_pc_q   <= '0;
    end else if (rdy_in) begin
      if (flush_in) begin
        cnt     <= '0;
        wptr    <= '0;
        rptr    <= '0;
        if_en_q <= 1'b0;
        bp_en_q <= 1'b0;
      end else begin
        if (push) wptr <= wptr + PTR_W'(1);
        if (pop)  rptr <= rptr + PTR_W'(1);
        case ({push, pop})
          2'b10:   cnt <= cnt + CNT_W'(1);
          2'b01:   cnt <= cnt - CNT_W'(1);
          default: cnt <= cnt;
        endcase
        if_en_q <= push && dec_jal;
        bp_en_q <= push && dec_br;
        if (push && dec_jal) if_addr_q <= jal_tgt;
        if (push && dec_br)  bp_pc_q   <= bus.iq_pc_in;
      end
    end
  end

  // A pulse held across a rdy_in=0 stall stays hidden until rdy_in returns.
  assign bus.if_en_out  = if_en_q && rdy_in;
  assign bus.iq_rst_out = if_en_q && rdy_in;
  assign bus.bp_en_out  = bp_en_q && rdy_in;
  assign bus.if_addr_out = if_addr_q;
  assign bus.bp_pc_out   = bp_pc_q;

  assign bus.disp_valid_out   = head_vld;
  assign bus.disp_opcode_out  = head.op;
  assign bus.disp_rs_out      = head.rs;
  assign bus.disp_rt_out      = head.rt;
  assign bus.disp_rd_out      = head.rd;
  assign bus.disp_imm_out     = head.imm;
  assign bus.disp_pc_out      = head.pc;
  assign bus.disp_illegal_out = head.illegal;
endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage. Expected decoded entries are hand-derived
// constants pushed into a scoreboard when the stage accepts an instruction;
// a negedge monitor pops and compares whenever the dispatcher consumes.
module tb_decode_stage;
  localparam int DEPTH = 2;
  localparam int AW    = 32;
  localparam int DW    = 32;

  localparam logic [5:0] NOP = 6'd0,  LUI = 6'd1,  JAL = 6'd3,  BEQ = 6'd5,
                         LW  = 6'd13, SW  = 6'd18, ADDI = 6'd19, SRAI = 6'd27,
                         ADD = 6'd28, SUB = 6'd29;

  typedef struct {
    logic [5:0]  op;
    logic [4:0]  rs, rt, rd;
    logic [31:0] imm, pc;
    logic        ill;
  } exp_t;

  logic clk = 1'b0, rst = 1'b1, rdy = 1'b1, flush = 1'b0;
  int   errors = 0, checks = 0;
  exp_t sb[$];

  decode_stage_if #(.ADDR_W(AW), .DATA_W(DW)) bus();

  decode_stage #(.DEPTH(DEPTH), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk_in(clk), .rst_in(rst), .rdy_in(rdy), .flush_in(flush), .bus(bus.slave)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  function automatic exp_t mk(input logic [5:0] op, input logic [4:0] rs, rt, rd,
                              input logic [31:0] imm, pc, input logic ill);
    exp_t e;
    e.op = op; e.rs = rs; e.rt = rt; e.rd = rd; e.imm = imm; e.pc = pc; e.ill = ill;
    return e;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_entry(input string tag, input exp_t e);
    chk({tag, "_op"},  bus.disp_opcode_out,  e.op);
    chk({tag, "_rs"},  bus.disp_rs_out,      e.rs);
    chk({tag, "_rt"},  bus.disp_rt_out,      e.rt);
    chk({tag, "_rd"},  bus.disp_rd_out,      e.rd);
    chk({tag, "_imm"}, bus.disp_imm_out,     e.imm);
    chk({tag, "_pc"},  bus.disp_pc_out,      e.pc);
    chk({tag, "_ill"}, bus.disp_illegal_out, e.ill);
  endtask

  // Head of FIFO versus oldest expected entry (dispatcher not consuming).
  task automatic check_head(input string tag);
    chk({tag, "_valid"}, bus.disp_valid_out, 1'b1);
    if (sb.size() == 0) chk({tag, "_sb_nonempty"}, sb.size(), 1);
    else check_entry(tag, sb[0]);
  endtask

  // Offer one instruction; returns at posedge+1 of the cycle after acceptance.
  task automatic push_inst(input logic [31:0] inst, pc, input exp_t e);
    int n = 0;
    bus.iq_valid_in = 1'b1; bus.iq_inst_in = inst; bus.iq_pc_in = pc;
    #1;
    while (!bus.iq_ready_out && n < 20) begin @(posedge clk); #1; n++; end
    if (!bus.iq_ready_out) chk("push_timeout", bus.iq_ready_out, 1'b1);
    else sb.push_back(e);
    @(posedge clk); #1;
    bus.iq_valid_in = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    bus.disp_ready_in = 1'b1;
    while (bus.disp_valid_out && n < 20) begin @(posedge clk); #1; n++; end
    chk("drain_empty", bus.disp_valid_out, 1'b0);
    bus.disp_ready_in = 1'b0;
  endtask

  // Scoreboard pop on every dispatcher consume.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && rdy && !flush && bus.disp_valid_out && bus.disp_ready_in) begin
      if (sb.size() == 0) chk("pop_unexpected", sb.size(), 1);
      else begin
        e = sb.pop_front();
        check_entry("pop", e);
      end
    end
  end

  initial begin
    bus.iq_valid_in = 1'b0; bus.iq_inst_in = '0; bus.iq_pc_in = '0;
    bus.disp_ready_in = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    // reset state
    chk("rst_valid", bus.disp_valid_out, 1'b0);
    chk("rst_op",    bus.disp_opcode_out, NOP);
    chk("rst_imm",   bus.disp_imm_out, 32'h0);
    chk("rst_if_en", bus.if_en_out, 1'b0);
    chk("rst_bp_en", bus.bp_en_out, 1'b0);
    chk("rst_if_addr", bus.if_addr_out, 32'h0);
    chk("rst_bp_pc", bus.bp_pc_out, 32'h0);
    #1 chk("rst_iq_ready", bus.iq_ready_out, 1'b1);

    // ADDI x1,x0,5 held at head while dispatcher stalls
    push_inst(32'h00500093, 32'h0, mk(ADDI, 0, 0, 1, 32'd5, 32'h0, 0));
    check_head("addi");
    repeat (2) begin @(posedge clk); #1; check_head("addi_hold"); end
    drain();

    // JAL x1,+8 -> one-cycle redirect to 0x108
    push_inst(32'h008000EF, 32'h100, mk(JAL, 0, 0, 1, 32'd8, 32'h100, 0));
    chk("jal_if_en",   bus.if_en_out, 1'b1);
    chk("jal_iq_rst",  bus.iq_rst_out, 1'b1);
    chk("jal_if_addr", bus.if_addr_out, 32'h108);
    chk("jal_bp_en",   bus.bp_en_out, 1'b0);
    check_head("jal");
    @(posedge clk); #1;
    chk("jal_if_en_drop",  bus.if_en_out, 1'b0);
    chk("jal_iq_rst_drop", bus.iq_rst_out, 1'b0);
    drain();

    // BEQ x0,x0,-4 -> predictor query
    push_inst(32'hFE000EE3, 32'h200, mk(BEQ, 0, 0, 0, 32'hFFFFFFFC, 32'h200, 0));
    chk("beq_bp_en", bus.bp_en_out, 1'b1);
    chk("beq_bp_pc", bus.bp_pc_out, 32'h200);
    chk("beq_if_en", bus.if_en_out, 1'b0);
    check_head("beq");
    @(posedge clk); #1;
    chk("beq_bp_en_drop", bus.bp_en_out, 1'b0);
    drain();

    // Fill the FIFO, third instruction must wait, then stream out in order
    push_inst(32'h002081B3, 32'h300, mk(ADD, 1, 2, 3, 32'h0, 32'h300, 0));
    push_inst(32'h40208233, 32'h304, mk(SUB, 1, 2, 4, 32'h0, 32'h304, 0));
    bus.iq_valid_in = 1'b1; bus.iq_inst_in = 32'h00C12283; bus.iq_pc_in = 32'h308;
    #1 chk("full_iq_ready", bus.iq_ready_out, 1'b0);
    @(posedge clk); #1;
    chk("full_iq_ready_hold", bus.iq_ready_out, 1'b0);
    check_head("full_head");
    bus.disp_ready_in = 1'b1;
    push_inst(32'h00C12283, 32'h308, mk(LW, 2, 0, 5, 32'd12, 32'h308, 0));
    drain();

    // SRAI with zero-extended shamt
    push_inst(32'h4020D093, 32'h400, mk(SRAI, 1, 0, 1, 32'd2, 32'h400, 0));
    check_head("srai");
    drain();
    // all-zero word is illegal: NOP, flag set, no pulses
    push_inst(32'h00000000, 32'h404, mk(NOP, 0, 0, 0, 32'h0, 32'h404, 1));
    check_head("illegal0");
    chk("illegal0_if_en", bus.if_en_out, 1'b0);
    chk("illegal0_bp_en", bus.bp_en_out, 1'b0);
    drain();

    // Streaming with dispatcher always ready: SW, LUI, BRANCH with funct3=2
    bus.disp_ready_in = 1'b1;
    push_inst(32'h0020A423, 32'h500, mk(SW, 1, 2, 0, 32'd8, 32'h500, 0));
    push_inst(32'h123453B7, 32'h504, mk(LUI, 0, 0, 7, 32'h12345000, 32'h504, 0));
    push_inst(32'h00002063, 32'h508, mk(NOP, 0, 0, 0, 32'h0, 32'h508, 1));
    chk("badbr_bp_en", bus.bp_en_out, 1'b0);
    drain();

    // Flush while full with a JAL offered; pending pulse already showing
    push_inst(32'h00500093, 32'h600, mk(ADDI, 0, 0, 1, 32'd5, 32'h600, 0));
    push_inst(32'h008000EF, 32'h604, mk(JAL, 0, 0, 1, 32'd8, 32'h604, 0));
    chk("pre_flush_if_en", bus.if_en_out, 1'b1);
    flush = 1'b1;
    bus.iq_valid_in = 1'b1; bus.iq_inst_in = 32'h008000EF; bus.iq_pc_in = 32'h608;
    #1 chk("flush_iq_ready", bus.iq_ready_out, 1'b0);
    @(posedge clk); #1;
    flush = 1'b0; bus.iq_valid_in = 1'b0;
    sb.delete();
    chk("flush_valid",  bus.disp_valid_out, 1'b0);
    chk("flush_if_en",  bus.if_en_out, 1'b0);
    chk("flush_iq_rst", bus.iq_rst_out, 1'b0);
    chk("flush_op",     bus.disp_opcode_out, NOP);
    #1 chk("flush_iq_ready_after", bus.iq_ready_out, 1'b1);
    push_inst(32'h00500093, 32'h700, mk(ADDI, 0, 0, 1, 32'd5, 32'h700, 0));
    check_head("post_flush");
    drain();

    // rdy_in low: no pop, no accept, pulses masked
    push_inst(32'h002081B3, 32'h800, mk(ADD, 1, 2, 3, 32'h0, 32'h800, 0));
    push_inst(32'h008000EF, 32'h804, mk(JAL, 0, 0, 1, 32'd8, 32'h804, 0));
    rdy = 1'b0;
    bus.disp_ready_in = 1'b1;
    #1;
    chk("stall_if_en",    bus.if_en_out, 1'b0);
    chk("stall_iq_rst",   bus.iq_rst_out, 1'b0);
    chk("stall_iq_ready", bus.iq_ready_out, 1'b0);
    repeat (2) begin @(posedge clk); #1; check_head("stall_hold"); end
    rdy = 1'b1;
    drain();

    chk("sb_empty", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
